// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus: memory read handshake plus the instruction delivery handshake.
// The master side belongs to the fetch unit; the slave side to the memory and processor.
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
);
  logic                   mem_req;
  logic [PC_WIDTH-1:0]    mem_addr;
  logic                   mem_ack;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch FSM (IDLE/REQ/OUT/HALT) with redirect support.
// Define FETCH_HALT_EN to make an accepted HALT_OPCODE park the unit in HALT until a redirect.
module fetch_unit #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] pc_counter,
  output logic                halted,
  fetch_unit_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [PC_WIDTH-1:0]    pc_reg, pc_next;
  logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
  logic [PC_WIDTH-1:0]    instr_pc_reg, instr_pc_next;
  logic                   halt_hit;

`ifdef FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
  assign halted = (state_reg == HALT);
`else
  localparam logic HALT_EN = 1'b0;
  assign halted = 1'b0;
`endif

  assign halt_hit = HALT_EN && (instr_reg == HALT_OPCODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;

    // A redirect overrides everything, including a same-cycle ack or accept.
    if (redirect_valid) begin
      pc_next    = redirect_pc;
      state_next = enable ? REQ : IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) state_next = REQ;
        end
        REQ: begin
          // enable is ignored here so an issued request always completes.
          if (bus.mem_ack) begin
            instr_next    = bus.mem_rdata;
            instr_pc_next = pc_reg;
            pc_next       = pc_reg + PC_WIDTH'(1);
            state_next    = OUT;
          end
        end
        OUT: begin
          if (bus.instr_ready) begin
            if (halt_hit)    state_next = HALT;
            else if (enable) state_next = REQ;
            else             state_next = IDLE;
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req     = (state_reg == REQ);
  assign bus.mem_addr    = pc_reg;
  assign bus.instr_valid = (state_reg == OUT);
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign pc_counter      = pc_reg;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8, SHALL set the program counter and memory address width.
REQ-002 Parameter INSTR_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-004 Parameter HALT_OPCODE, default all-ones INSTR_WIDTH-bit word, SHALL set the halt encoding.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 enable  input  1  SHALL be the fetch permit; 0 stops new memory requests.
REQ-008 redirect_valid  input  1  SHALL request a PC redirect (branch/jump).
REQ-009 redirect_pc  input  PC_WIDTH  SHALL be the redirect target.
REQ-010 mem_req  output  1  SHALL be the instruction memory read request.
REQ-011 mem_addr  output  PC_WIDTH  SHALL be the read address; it equals pc.
REQ-012 mem_ack  input  1  SHALL mean mem_rdata is valid this cycle.
REQ-013 mem_rdata  input  INSTR_WIDTH  SHALL be the instruction read data.
REQ-014 instr_valid  output  1  SHALL mean instr/instr_pc hold a fetched instruction.
REQ-015 instr_ready  input  1  SHALL mean the processor accepts the instruction.
REQ-016 instr  output  INSTR_WIDTH  SHALL be the fetched instruction word.
REQ-017 instr_pc  output  PC_WIDTH  SHALL be the PC the instruction was fetched from.
REQ-018 pc_counter  output  PC_WIDTH  SHALL expose the current pc register to the processor.
REQ-019 halted  output  1  SHALL flag the HALT state.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, OUT and HALT; mem_req SHALL be 1 only in REQ, and instr_valid SHALL be 1 only in OUT.
REQ-021 IDLE SHALL go to REQ on the next edge when enable=1; otherwise it stays in IDLE.
REQ-022 In REQ with mem_ack=1, the block SHALL capture instr<=mem_rdata and instr_pc<=pc, set pc<=pc+1 modulo 2^PC_WIDTH, and go to OUT.
REQ-023 mem_addr SHALL stay stable while in REQ without mem_ack; enable=0 SHALL NOT abort an outstanding request.
REQ-024 instr and instr_pc SHALL stay stable in OUT until instr_ready=1; on accept, the FSM SHALL go to REQ if enable=1, else to IDLE.
REQ-025 Minimum throughput SHALL be one instruction per 2 cycles (ack in the first REQ cycle and ready in the first OUT cycle).
REQ-026 Increment at pc=2^PC_WIDTH-1 SHALL wrap to 0 with no flag.
REQ-027 redirect_valid=1 in any state SHALL load pc<=redirect_pc and go to REQ if enable=1, else to IDLE.
REQ-028 Redirect SHALL take priority over mem_ack and instr_ready in the same cycle; the acknowledged data SHALL be discarded and instr_valid SHALL be 0 next cycle.
REQ-029 Redirect SHALL be the only exit from HALT; halted SHALL clear on that edge.
REQ-030 instr and instr_pc SHALL keep their last values outside OUT.

Reset
REQ-031 While reset=1, the block SHALL asynchronously force state=IDLE, pc=RESET_PC, instr=0, instr_pc=0 and halted=0, giving mem_req=0 and instr_valid=0.
REQ-032 Reset asserted mid-request SHALL abandon the request; a mem_ack arriving during or after reset SHALL be ignored unless the block is in REQ.
REQ-033 After reset deasserts with enable=1, the first mem_req SHALL assert on the second rising edge (IDLE, then REQ).

Configuration
REQ-034 With FETCH_HALT_EN defined, accepting an instruction (OUT with instr_ready=1 and no redirect) whose instr equals HALT_OPCODE SHALL go to HALT; HALT SHALL set halted=1, mem_req=0 and instr_valid=0.
REQ-035 With FETCH_HALT_EN undefined, HALT_OPCODE SHALL be an ordinary instruction, the HALT state SHALL be unreachable, and halted SHALL be constant 0.

Verification
REQ-036 Reset, then enable=1, mem_ack=1 in every REQ cycle, instr_ready=1, mem_rdata=0x1000_0000+addr -> mem_addr sequence 0,1,2,3; instr_pc 0,1,2,3; one instr_valid every 2 cycles.
REQ-037 pc=0xFF, fetch accepted -> instr_pc=0xFF and the next mem_addr=0x00.
REQ-038 In OUT, hold instr_ready=0 for 5 cycles -> instr and instr_pc stable, no mem_req; on ready=1, REQ the next cycle.
REQ-039 In REQ, assert mem_ack=1 and redirect_valid=1 with redirect_pc=0x40 in the same cycle -> data dropped, instr_valid stays 0, next mem_addr=0x40.
REQ-040 With FETCH_HALT_EN defined, deliver 0xFFFF_FFFF and accept it -> halted=1 and mem_req stays 0 for 10 cycles; redirect to 0x10 -> halted=0, mem_addr=0x10. Without the macro, the same stimulus gives halted=0 and fetch continues.
REQ-041 Assert reset for 1 cycle while in REQ -> mem_req=0 and pc=RESET_PC immediately (asynchronous), and a mem_ack during reset is ignored.
